// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer with CDB capture, in-order single
// commit per cycle onto the sal_t commit bus, and two combinational
// lookup ports for dispatch-time forwarding of completed results.

package rob_commit_pkg;
    localparam int SAL_W = 32;

    // Commit bus consumed by the register file to clear busy bits.
    typedef struct packed {
        logic             rdy;
        logic [3:0]       tag;
        logic [SAL_W-1:0] data;
    } sal_t;
endpackage

module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SAL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    output logic [3:0]       issue_tag,
    input  logic             cdb_valid,
    input  logic [3:0]       cdb_tag,
    input  logic [WIDTH-1:0] cdb_data,
    input  logic             flush,
    input  logic [3:0]       q1_tag,
    input  logic [3:0]       q2_tag,
    output logic             q1_done,
    output logic             q2_done,
    output logic [WIDTH-1:0] q1_data,
    output logic [WIDTH-1:0] q2_data,
    output sal_t             rdest,
    output logic [4:0]       count
);

    localparam logic [4:0] FULL = 5'd16;

    // Per-entry state. valid/done are control and are reset; the payload
    // (rd, data) is only meaningful while done is set, so it is not reset.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_done;
    logic [4:0]       ent_rd   [DEPTH];
    logic [WIDTH-1:0] ent_data [DEPTH];

    logic [3:0] head;
    logic [3:0] tail;

    logic do_issue;
    logic do_cdb;
    logic do_commit;

    // Readiness comes from registered occupancy only; a slot freed by this
    // cycle's commit becomes allocatable on the following cycle.
    assign issue_ready = (count != FULL);
    assign issue_tag   = tail;

    // Event qualification, all from registered state. Commit looks at the
    // stored done bit, so a CDB hit on the head entry retires one edge later.
    assign do_issue  = issue_valid && issue_ready;
    assign do_cdb    = cdb_valid && ent_valid[cdb_tag];
    assign do_commit = ent_valid[head] && ent_done[head];

    // Control state: entry flags, pointers, occupancy and the commit bus.
    // Flush overrides every concurrent issue, capture and commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rdest     <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rdest.rdy <= 1'b0;
        end else begin
            // Tag and data hold their last value when nothing retires.
            rdest.rdy <= do_commit;
            if (do_commit) begin
                rdest.tag       <= head;
                rdest.data      <= ent_data[head];
                ent_valid[head] <= 1'b0;
                head            <= head + 4'd1;
            end
            // A capture only targets valid entries, and a free tail entry is
            // never valid, so capture and allocation never hit the same slot.
            if (do_cdb) begin
                ent_done[cdb_tag] <= 1'b1;
            end
            if (do_issue) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + 4'd1;
            end
            count <= count + {4'd0, do_issue} - {4'd0, do_commit};
        end
    end

    // Entry payload: destination register at allocation, result at capture.
    always_ff @(posedge clk) begin
        if (!flush && do_cdb) begin
            ent_data[cdb_tag] <= cdb_data;
        end
        if (!flush && do_issue) begin
            ent_rd[tail] <= issue_rd;
        end
    end

    // Forwarding lookups read registered state only; no same-cycle CDB bypass.
    always_comb begin
        q1_done = ent_valid[q1_tag] && ent_done[q1_tag];
        q2_done = ent_valid[q2_tag] && ent_done[q2_tag];
        q1_data = q1_done ? ent_data[q1_tag] : '0;
        q2_data = q2_done ? ent_data[q2_tag] : '0;
    end

endmodule

// File: tb/tb_rob_commit.sv
// Testbench for rob_commit: directed scenarios plus randomized traffic,
// checked against a program-order queue model of the reorder buffer.

module tb_rob_commit;
    import rob_commit_pkg::*;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [3:0]  issue_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic [3:0]  q1_tag;
    logic [3:0]  q2_tag;
    logic        q1_done;
    logic        q2_done;
    logic [31:0] q1_data;
    logic [31:0] q2_data;
    sal_t        rdest;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    rob_commit dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_done(q1_done), .q2_done(q2_done),
        .q1_data(q1_data), .q2_data(q2_data),
        .rdest(rdest), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight instructions in program order.
    typedef struct {
        logic [3:0]  tag;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_next;
    sal_t m_rdest;

    function automatic void model_reset();
        mq.delete();
        m_next  = 0;
        m_rdest = '0;
    endfunction

    function automatic void model_edge();
        bit   com;
        int   pre;
        ent_t e;
        if (flush) begin
            mq.delete();
            m_next      = 0;
            m_rdest.rdy = 1'b0;
            return;
        end
        pre = mq.size();
        com = (pre > 0) && mq[0].done;
        if (com) begin
            m_rdest.rdy  = 1'b1;
            m_rdest.tag  = mq[0].tag;
            m_rdest.data = mq[0].data;
        end else begin
            m_rdest.rdy = 1'b0;
        end
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == cdb_tag) begin
                    mq[i].done = 1'b1;
                    mq[i].data = cdb_data;
                end
            end
        end
        if (com) void'(mq.pop_front());
        if (issue_valid && pre < 16) begin
            e.tag  = m_next[3:0];
            e.done = 1'b0;
            e.data = '0;
            mq.push_back(e);
            m_next = (m_next + 1) % 16;
        end
    endfunction

    function automatic void m_lookup(input logic [3:0] t, output bit d, output logic [31:0] v);
        d = 1'b0;
        v = '0;
        foreach (mq[i]) begin
            if (mq[i].tag == t && mq[i].done) begin
                d = 1'b1;
                v = mq[i].data;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        issue_rd = '0; cdb_tag = '0; cdb_data = '0; q1_tag = '0; q2_tag = '0;
        model_reset();
        #2;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (issue_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", issue_tag); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", issue_ready); end
        n_checks++; if (rdest !== '0) begin n_fail++; $display("FAIL reset_rdest got %0h want 0", rdest); end
        n_checks++; if (q1_done !== 1'b0 || q1_data !== 32'd0) begin n_fail++; $display("FAIL reset_q1 got %0b/%0h want 0/0", q1_done, q1_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_in_order();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_rd = 5'(5 + i);
            n_checks++; if (issue_tag !== 4'(i)) begin n_fail++; $display("FAIL order_issue_tag got %0d want %0d", issue_tag, i); end
            tick();
        end
        idle();
        cdb_valid = 1'b1;
        cdb_tag = 4'd2; cdb_data = 32'hC; tick();
        cdb_tag = 4'd0; cdb_data = 32'hA; tick();
        n_checks++; if (rdest.rdy !== 1'b0) begin n_fail++; $display("FAIL order_early_rdy got %0b want 0", rdest.rdy); end
        cdb_tag = 4'd1; cdb_data = 32'hB; tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rdest.rdy !== 1'b1 || rdest.tag !== 4'(i) || rdest.data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL order_commit%0d got rdy=%0b tag=%0d data=%0h want rdy=1 tag=%0d data=%0h",
                         i, rdest.rdy, rdest.tag, rdest.data, i, exp_d[i]);
            end
            tick();
        end
        n_checks++; if (rdest.rdy !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL order_drain got rdy=%0b count=%0d want 0/0", rdest.rdy, count); end
    endtask

    task automatic test_full_wrap();
        flush = 1'b1; tick(); idle();
        issue_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue_rd = 5'(i);
            tick();
        end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", count); end
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", issue_ready); end
        tick();
        n_checks++; if (count !== 5'd16 || issue_tag !== 4'd0) begin n_fail++; $display("FAIL full_17th got count=%0d tag=%0d want 16/0", count, issue_tag); end
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h100; tick();
        idle(); tick();
        n_checks++; if (count !== 5'd15 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_retire got count=%0d ready=%0b want 15/1", count, issue_ready); end
        n_checks++; if (rdest.rdy !== 1'b1 || rdest.tag !== 4'd0 || rdest.data !== 32'h100) begin n_fail++; $display("FAIL full_commit got rdy=%0b tag=%0d data=%0h want 1/0/100", rdest.rdy, rdest.tag, rdest.data); end
        issue_valid = 1'b1;
        n_checks++; if (issue_tag !== 4'd0) begin n_fail++; $display("FAIL wrap_tag got %0d want 0", issue_tag); end
        tick(); idle();
        n_checks++; if (count !== 5'd16 || issue_tag !== 4'd1) begin n_fail++; $display("FAIL wrap_after got count=%0d tag=%0d want 16/1", count, issue_tag); end
    endtask

    task automatic test_simul();
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h11; tick();
        idle(); tick();
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL simul_pre got %0d want 15", count); end
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h22; tick();
        idle();
        issue_valid = 1'b1; tick(); idle();
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL simul_count got %0d want 15", count); end
        n_checks++; if (issue_tag !== 4'd2) begin n_fail++; $display("FAIL simul_tag got %0d want 2", issue_tag); end
        n_checks++; if (rdest.rdy !== 1'b1 || rdest.tag !== 4'd2 || rdest.data !== 32'h22) begin n_fail++; $display("FAIL simul_commit got rdy=%0b tag=%0d data=%0h want 1/2/22", rdest.rdy, rdest.tag, rdest.data); end
    endtask

    task automatic test_forward();
        flush = 1'b1; tick(); idle();
        issue_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h55; tick();
        idle();
        q1_tag = 4'd3; q2_tag = 4'd4; #1;
        n_checks++; if (q1_done !== 1'b1 || q1_data !== 32'h55) begin n_fail++; $display("FAIL fwd_hit got %0b/%0h want 1/55", q1_done, q1_data); end
        n_checks++; if (q2_done !== 1'b0 || q2_data !== 32'h0) begin n_fail++; $display("FAIL fwd_miss got %0b/%0h want 0/0", q2_done, q2_data); end
        cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 32'h66; #1;
        n_checks++; if (q2_done !== 1'b0) begin n_fail++; $display("FAIL fwd_nobypass got %0b want 0", q2_done); end
        tick(); idle();
        n_checks++; if (q2_done !== 1'b1 || q2_data !== 32'h66) begin n_fail++; $display("FAIL fwd_late got %0b/%0h want 1/66", q2_done, q2_data); end
        n_checks++; if (rdest.rdy !== 1'b0 || count !== 5'd5) begin n_fail++; $display("FAIL fwd_hold got rdy=%0b count=%0d want 0/5", rdest.rdy, count); end
    endtask

    task automatic test_flush();
        flush = 1'b1; issue_valid = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h77;
        tick(); idle();
        n_checks++; if (count !== 5'd0 || issue_tag !== 4'd0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got count=%0d tag=%0d ready=%0b want 0/0/1", count, issue_tag, issue_ready); end
        n_checks++; if (rdest.rdy !== 1'b0) begin n_fail++; $display("FAIL flush_rdy got %0b want 0", rdest.rdy); end
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h99; q1_tag = 4'd3;
        tick(); idle(); tick();
        n_checks++; if (q1_done !== 1'b0 || q1_data !== 32'h0) begin n_fail++; $display("FAIL flush_stale got %0b/%0h want 0/0", q1_done, q1_data); end
        n_checks++; if (count !== 5'd0 || rdest.rdy !== 1'b0) begin n_fail++; $display("FAIL flush_after got count=%0d rdy=%0b want 0/0", count, rdest.rdy); end
    endtask

    task automatic test_reset_midop();
        issue_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue_rd = 5'(i + 1);
            tick();
        end
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h5; tick(); idle(); tick();
        n_checks++; if (count !== 5'd6 || rdest.rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got count=%0d rdy=%0b want 6/1", count, rdest.rdy); end
        issue_valid = 1'b1; tick(); idle();
        n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL midrst_seven got %0d want 7", count); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", count); end
        n_checks++; if (issue_tag !== 4'd0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_issue got tag=%0d ready=%0b want 0/1", issue_tag, issue_ready); end
        n_checks++; if (rdest !== '0) begin n_fail++; $display("FAIL midrst_rdest got %0h want 0", rdest); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit          d1, d2;
        logic [31:0] v1, v2;
        for (int c = 0; c < 2000; c++) begin
            issue_valid = ($urandom_range(0, 99) < 60);
            issue_rd    = 5'($urandom);
            cdb_valid   = ($urandom_range(0, 99) < 55);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                cdb_tag = 4'($urandom);
            cdb_data = $urandom;
            flush    = ($urandom_range(0, 63) == 0);
            q1_tag   = 4'($urandom);
            q2_tag   = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'($urandom);
            tick();
            m_lookup(q1_tag, d1, v1);
            m_lookup(q2_tag, d2, v2);
            n_checks++; if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, mq.size()); end
            n_checks++; if (issue_tag !== 4'(m_next)) begin n_fail++; $display("FAIL rnd_tag c=%0d got %0d want %0d", c, issue_tag, m_next); end
            n_checks++; if (issue_ready !== (mq.size() != 16)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, issue_ready, mq.size() != 16); end
            n_checks++; if (rdest !== m_rdest) begin n_fail++; $display("FAIL rnd_rdest c=%0d got %0h want %0h", c, rdest, m_rdest); end
            n_checks++; if (q1_done !== d1 || q1_data !== v1) begin n_fail++; $display("FAIL rnd_q1 c=%0d got %0b/%0h want %0b/%0h", c, q1_done, q1_data, d1, v1); end
            n_checks++; if (q2_done !== d2 || q2_data !== v2) begin n_fail++; $display("FAIL rnd_q2 c=%0d got %0b/%0h want %0b/%0h", c, q2_done, q2_data, d2, v2); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_simul();
        test_forward();
        test_flush();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer for the out-of-order core. It allocates a 4-bit tag for every issued instruction and captures results broadcast on the CDB. It retires finished entries strictly in program order, one per cycle, onto the `sal_t` commit bus that the register file consumes to clear busy bits. It also exposes two combinational lookup ports so dispatch can forward results that are complete but not yet committed.

## Interface
- `DEPTH`, 16: entry count. Fixed to 16 because tags are 4 bits wide.
- `WIDTH`, 32: data width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `issue_valid`  in  1  allocate one entry this cycle.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `issue_ready`  out  1  at least one entry is free.
- `issue_tag`  out  4  tag the next allocation receives (tail pointer). Drives `rd_tag` of the regfile.
- `cdb_valid`  in  1  result broadcast valid.
- `cdb_tag`  in  4  tag of the broadcast result.
- `cdb_data`  in  WIDTH  broadcast result value.
- `flush`  in  1  discard all entries (synchronous).
- `q1_tag`, `q2_tag`  in  4  lookup tags.
- `q1_done`, `q2_done`  out  1  the looked-up entry is valid and its result is captured.
- `q1_data`, `q2_data`  out  WIDTH  captured result; 0 when not done.
- `rdest`  out  sal_t  commit bus, with fields `rdy`, `tag`, `data`.
- `count`  out  5  occupied entries, 0..16.

## Operation
- **Storage.** Each entry holds `valid`, `done`, `rd[4:0]` and `data[WIDTH-1:0]`. The 4-bit `head` and `tail` pointers wrap from 15 to 0. A 5-bit `count` distinguishes full from empty.
- **Issue.** Fires when `issue_valid && issue_ready`.
  - Entry[tail] becomes `valid=1`, `done=0`, `rd=issue_rd`.
  - `tail` increments and `count` increments.
  - `issue_valid` while `issue_ready=0` is ignored and changes no state.
- **CDB capture.** Fires when `cdb_valid` is high and entry[cdb_tag].valid is set.
  - Entry gets `done=1` and `data=cdb_data`.
  - A CDB write to an invalid entry is ignored.
  - A repeated CDB write to a done entry overwrites the data.
- **Commit.** Fires when entry[head] is valid and done.
  - Registers `rdest` <= {rdy=1, tag=head, data=entry.data}.
  - Clears entry[head].valid, increments `head` and decrements `count`.
  - Otherwise registers `rdest.rdy`=0; `tag` and `data` hold their last value.
  - At most one commit per cycle.
  - An entry with `rd=0` still commits; the regfile discards writes to x0.
- **Simultaneous events.** Issue, CDB capture and commit in the same cycle are all performed, and `count` changes by (issue − commit).
  - `issue_ready` is `count != 16`, taken from registered state. There is no same-cycle bypass of a freed slot.
  - A CDB write to the head entry is not committed in the same cycle; it commits on the following edge.
- **Flush.** Has highest priority.
  - On the next edge: all `valid`/`done` cleared, `head=tail=0`, `count=0`, `rdest.rdy=0`.
  - Concurrent issue, CDB and commit are dropped.
- **Lookup.** `qN_done = entry[qN_tag].valid && entry[qN_tag].done` and `qN_data = qN_done ? entry.data : 0`. Both are purely combinational from registered state; there is no bypass of the same-cycle CDB.
- **Reset values (async, `rst=0`).** All entries cleared, `head=tail=0`, `count=0`, `issue_tag=0`, `issue_ready=1`, `rdest` all-zero, query outputs 0.

## Timing
- **Issue to tag.** The tag is `issue_tag` in the issue cycle. The regfile latches it at the same edge that allocates the entry.
- **CDB to commit.** CDB sampled at edge E; the earliest commit registers at E+1; `rdest.rdy` is high during E+1..E+2; the regfile updates at E+2.
- **Throughput.** Sustained throughput is one commit per cycle when consecutive head entries are done.
- **Freed slot.** A freed slot is allocatable from the cycle after the commit edge.
- **Reset.** Assertion takes effect immediately. Deassertion is synchronized externally; the first active edge follows deassertion.

## Test plan
- **Reset.** Drive `rst` low mid-operation with count=7 → all outputs immediately at reset values: `count=0`, `issue_tag=0`, `issue_ready=1`, `rdest.rdy=0`.
- **In-order retire.** Issue 3 entries (tags 0,1,2, rd 5,6,7). CDB tag 2 (0xC), then tag 0 (0xA), then tag 1 (0xB). Expect commits in tag order 0,1,2 with data 0xA,0xB,0xC on consecutive cycles, starting the cycle after tag 1 is captured.
- **Full/wrap.** Issue 16 → `issue_ready=0`, `count=16`; a 17th `issue_valid` is ignored. Retire 1 → the next issue receives tag 0 after `tail` wraps.
- **Simultaneous issue+commit at count=15.** One issue and one commit in the same cycle → count stays 15 and `issue_tag` advances by 1.
- **Forwarding.** CDB tag 3 = 0x55 while head=0 is not done → next cycle `q1_tag=3` gives `q1_done=1`, `q1_data=0x55`; a lookup of tag 4 (not done) gives 0/0.
- **Flush.** Flush with 5 pending entries plus concurrent issue and CDB → next cycle `count=0`, `issue_tag=0`, no `rdest.rdy`, a stale CDB to an old tag is ignored.
